// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: start bit, DATA_W data bits LSB first,
// optional odd/even parity and 1 or 2 stop bits, one word per valid/ready handshake.
module uart_tx_frame #(
    parameter int CLK_DIV   = 434,
    parameter int DATA_W    = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              txd,
    output logic              busy,
    output logic              done
);
    localparam int BAUD_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
    localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLK_DIV - 2);
    localparam logic [3:0]        DATA_LAST = 4'(DATA_W - 1);
    localparam logic [3:0]        STOP_LAST = 4'(STOP_BITS - 1);

    if (CLK_DIV < 2 || DATA_W < 5 || DATA_W > 9 || PARITY < 0 || PARITY > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_params
        $error("uart_tx_frame: illegal parameter set");
    end

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t            state;
    logic [BAUD_W-1:0] baud_cnt;
    logic [3:0]        bit_cnt;
    logic [DATA_W-1:0] shreg;
    logic              par_bit;
    logic              bit_end;
    logic              hs;

    function automatic logic parity_of(input logic [DATA_W-1:0] d);
        return (PARITY == 1) ? ~(^d) : (^d);
    endfunction

    assign bit_end = (baud_cnt == BAUD_LAST);
    assign hs      = (state == IDLE) && s_valid && s_ready;

    // Datapath: word and parity are frozen at the handshake, then shifted out LSB first
    always_ff @(posedge clk) begin
        if (hs) begin
            shreg   <= s_data;
            par_bit <= parity_of(s_data);
        end else if (bit_end && (state == START || state == DATA)) begin
            shreg <= shreg >> 1;
        end
    end

    // Control: txd is loaded with the next frame bit on the edge that ends the current one
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            txd      <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            s_ready  <= 1'b1;
        end else begin
            // Registered one cycle early so the pulse lands on the final stop-bit cycle
            done <= (state == STOP) && (bit_cnt == STOP_LAST) && (baud_cnt == BAUD_PRE);
            if (state == IDLE || bit_end) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (hs) begin
                        state   <= START;
                        txd     <= 1'b0;
                        busy    <= 1'b1;
                        s_ready <= 1'b0;
                        bit_cnt <= '0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state   <= DATA;
                        txd     <= shreg[0];
                        bit_cnt <= '0;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
                            if (PARITY != 0) begin
                                state <= PAR;
                                txd   <= par_bit;
                            end else begin
                                state <= STOP;
                                txd   <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            txd     <= shreg[0];
                        end
                    end
                end
                PAR: begin
                    if (bit_end) begin
                        state   <= STOP;
                        txd     <= 1'b1;
                        bit_cnt <= '0;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (bit_cnt == STOP_LAST) begin
                            state   <= IDLE;
                            busy    <= 1'b0;
                            s_ready <= 1'b1;
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: four configurations checked every cycle against a frame-level model.
module tb_uart_tx_frame;
    localparam int NI = 4;
    localparam int P_DIV  [NI] = '{4, 4, 4, 3};
    localparam int P_DW   [NI] = '{8, 8, 8, 7};
    localparam int P_PAR  [NI] = '{0, 2, 1, 0};
    localparam int P_STOP [NI] = '{1, 1, 1, 2};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [NI-1:0] n_rst_v, s_valid_v, ready_v, txd_v, busy_v, done_v;
    logic [8:0]    s_data_v [NI];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit started = 0;

    bit          m_act    [NI];
    int          m_t      [NI];
    int          m_hs     [NI];
    logic [15:0] m_frame  [NI];
    logic [3:0]  m_exp    [NI];
    int          done_cyc [NI];
    int          done_cnt [NI];

    uart_tx_frame #(.CLK_DIV(4), .DATA_W(8), .PARITY(0), .STOP_BITS(1)) u0 (
        .clk(clk), .n_rst(n_rst_v[0]), .s_data(s_data_v[0][7:0]), .s_valid(s_valid_v[0]),
        .s_ready(ready_v[0]), .txd(txd_v[0]), .busy(busy_v[0]), .done(done_v[0]));
    uart_tx_frame #(.CLK_DIV(4), .DATA_W(8), .PARITY(2), .STOP_BITS(1)) u1 (
        .clk(clk), .n_rst(n_rst_v[1]), .s_data(s_data_v[1][7:0]), .s_valid(s_valid_v[1]),
        .s_ready(ready_v[1]), .txd(txd_v[1]), .busy(busy_v[1]), .done(done_v[1]));
    uart_tx_frame #(.CLK_DIV(4), .DATA_W(8), .PARITY(1), .STOP_BITS(1)) u2 (
        .clk(clk), .n_rst(n_rst_v[2]), .s_data(s_data_v[2][7:0]), .s_valid(s_valid_v[2]),
        .s_ready(ready_v[2]), .txd(txd_v[2]), .busy(busy_v[2]), .done(done_v[2]));
    uart_tx_frame #(.CLK_DIV(3), .DATA_W(7), .PARITY(0), .STOP_BITS(2)) u3 (
        .clk(clk), .n_rst(n_rst_v[3]), .s_data(s_data_v[3][6:0]), .s_valid(s_valid_v[3]),
        .s_ready(ready_v[3]), .txd(txd_v[3]), .busy(busy_v[3]), .done(done_v[3]));

    function automatic int frame_len(int i);
        return 1 + P_DW[i] + ((P_PAR[i] != 0) ? 1 : 0) + P_STOP[i];
    endfunction

    // Frame as a bit list: bit k is what the line carries during bit period k
    function automatic logic [15:0] build_frame(logic [8:0] d, int dw, int par);
        logic [15:0] f;
        logic p;
        int k;
        f = '1;
        p = 1'b0;
        f[0] = 1'b0;
        k = 1;
        for (int j = 0; j < dw; j++) begin
            f[k] = d[j];
            p = p ^ d[j];
            k++;
        end
        if (par != 0) f[k] = (par == 1) ? ~p : p;
        return f;
    endfunction

    always @(posedge clk) begin
        int n, k, len;
        for (int i = 0; i < NI; i++) begin
            len = frame_len(i) * P_DIV[i];
            if (!n_rst_v[i]) begin
                m_act[i] = 1'b0;
            end else if (m_act[i] && cyc == m_t[i] + len) begin
                m_act[i] = 1'b0;
            end else if (!m_act[i] && s_valid_v[i]) begin
                m_act[i]   = 1'b1;
                m_t[i]     = cyc;
                m_hs[i]    = m_hs[i] + 1;
                m_frame[i] = build_frame(s_data_v[i], P_DW[i], P_PAR[i]);
            end
            n = cyc + 1;
            if (!m_act[i]) begin
                m_exp[i] = 4'b1010;
            end else begin
                k = (n - m_t[i] - 1) / P_DIV[i];
                m_exp[i] = {m_frame[i][k], 1'b1, 1'b0, (n == m_t[i] + len)};
            end
        end
        cyc = cyc + 1;
        started = 1'b1;
    end

    always @(negedge clk) begin
        logic [3:0] act;
        if (started) begin
            for (int i = 0; i < NI; i++) begin
                act = {txd_v[i], busy_v[i], ready_v[i], done_v[i]};
                checks++;
                if (act !== m_exp[i]) begin
                    failures++;
                    $display("FAIL cycle_u%0d cyc=%0d {txd,busy,ready,done} got=%b want=%b",
                             i, cyc, act, m_exp[i]);
                end
                if (done_v[i] === 1'b1) begin
                    done_cyc[i] = cyc;
                    done_cnt[i] = done_cnt[i] + 1;
                end
            end
        end
    end

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic wait_hs(input int i, input int target);
        for (int w = 0; w < 200 && m_hs[i] < target; w++) @(negedge clk);
        if (m_hs[i] < target) chk("hs_timeout", m_hs[i], target);
    endtask

    task automatic send(input int i, input logic [8:0] d, output int t);
        int h0;
        h0 = m_hs[i];
        @(negedge clk);
        s_data_v[i]  = d;
        s_valid_v[i] = 1'b1;
        wait_hs(i, h0 + 1);
        s_valid_v[i] = 1'b0;
        t = m_t[i];
    endtask

    task automatic wait_idle(input int i);
        for (int w = 0; w < 300 && m_act[i]; w++) @(negedge clk);
        if (m_act[i]) chk("idle_timeout", 1, 0);
    endtask

    initial begin
        int t, t1, t2, h0, d0;
        logic [15:0] f;
        n_rst_v   = '0;
        s_valid_v = '0;
        for (int i = 0; i < NI; i++) s_data_v[i] = '0;
        repeat (3) @(negedge clk);
        n_rst_v = '1;
        @(negedge clk);
        chk("ready_after_reset", int'(ready_v), 15);
        chk("txd_after_reset", int'(txd_v), 15);

        f = build_frame(9'h0A5, 8, 0);
        chk("model_frame_a5", int'(f[9:0]), 'h34A);
        f = build_frame(9'h007, 8, 2);
        chk("model_frame_07_even", int'(f[10:0]), 'h60E);
        f = build_frame(9'h007, 8, 1);
        chk("model_frame_07_odd", int'(f[10:0]), 'h40E);
        f = build_frame(9'h041, 7, 0);
        chk("model_frame_41_7n2", int'(f[11:0]), 'hF82);

        send(0, 9'h0A5, t);
        wait_idle(0);
        chk("a5_done_offset", done_cyc[0] - t, 40);
        chk("a5_ready_back_cycle", cyc - t, 41);
        chk("a5_ready_back", int'(ready_v[0]), 1);

        send(1, 9'h007, t);
        wait_idle(1);
        chk("even_done_offset", done_cyc[1] - t, 44);
        send(2, 9'h007, t);
        wait_idle(2);
        chk("odd_done_offset", done_cyc[2] - t, 44);

        send(3, 9'h041, t);
        wait_idle(3);
        chk("7n2_done_offset", done_cyc[3] - t, 30);

        h0 = m_hs[0];
        @(negedge clk);
        s_data_v[0]  = 9'h055;
        s_valid_v[0] = 1'b1;
        wait_hs(0, h0 + 1);
        t1 = m_t[0];
        s_data_v[0] = 9'h0AA;
        wait_hs(0, h0 + 2);
        t2 = m_t[0];
        s_valid_v[0] = 1'b0;
        chk("b2b_second_hs", t2 - t1, 41);
        wait_idle(0);
        chk("b2b_second_done", done_cyc[0] - t1, 81);

        d0 = done_cnt[0];
        send(0, 9'h0F0, t);
        for (int w = 0; w < 50 && cyc < t + 18; w++) @(negedge clk);
        n_rst_v[0] = 1'b0;
        @(negedge clk);
        n_rst_v[0] = 1'b1;
        chk("abort_txd", int'(txd_v[0]), 1);
        chk("abort_busy", int'(busy_v[0]), 0);
        chk("abort_ready", int'(ready_v[0]), 1);
        repeat (30) @(negedge clk);
        chk("abort_no_done", done_cnt[0] - d0, 0);
        send(0, 9'h03C, t);
        wait_idle(0);
        chk("after_abort_done_offset", done_cyc[0] - t, 40);

        h0 = m_hs[0];
        @(negedge clk);
        s_data_v[0]  = 9'h0C3;
        s_valid_v[0] = 1'b1;
        wait_hs(0, h0 + 1);
        for (int w = 0; w < 200 && m_hs[0] < h0 + 2; w++) begin
            s_data_v[0] = 9'($urandom);
            @(negedge clk);
        end
        s_valid_v[0] = 1'b0;
        chk("scramble_two_frames", m_hs[0] - h0, 2);
        wait_idle(0);
        repeat (5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
